branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of BTB entries (power of two, 2..256).
REQ-002 SHALL have parameter XLEN, default 32, address width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port PCF, input, XLEN, fetch-stage PC.
REQ-006 SHALL have port PredTakenF, output, 1, fetch-stage taken prediction.
REQ-007 SHALL have port PredTargetF, output, XLEN, fetch-stage predicted target.
REQ-008 SHALL have ports PCE, PCPlus4E and PCTargetE, input, XLEN each, execute-stage PC, fall-through address and computed target.
REQ-009 SHALL have ports BranchE, JumpE and PCSrcE, input, 1 each, execute-stage control class and resolved outcome.
REQ-010 SHALL have ports PredTakenE (1) and PredTargetE (XLEN), input, the prediction carried down the pipeline with the instruction.
REQ-011 SHALL have port MispredictE, output, 1, flush/redirect request.
REQ-012 SHALL have port RedirectPCE, output, XLEN, corrected fetch address.

Function
REQ-013 SHALL be a direct-mapped BTB; index = PC[log2(ENTRIES)+1:2], tag = PC[XLEN-1:log2(ENTRIES)+2]; each entry holds valid, tag, target and a 2-bit counter.
REQ-014 SHALL perform the lookup combinationally with zero latency: hit = valid and tag match; PredTakenF = hit and counter[1]; PredTargetF = entry target on a hit, else PCF+4.
REQ-015 SHALL set MispredictE = (BranchE|JumpE) & ((PCSrcE != PredTakenE) | (PCSrcE & PredTakenE & (PredTargetE != PCTargetE))) | (~BranchE & ~JumpE & PredTakenE).
REQ-016 SHALL set RedirectPCE = PCTargetE when (BranchE|JumpE) & PCSrcE, else PCPlus4E.
REQ-017 SHALL compute MispredictE and RedirectPCE combinationally, with no internal registering.
REQ-018 On BranchE with an entry hit at PCE, SHALL update the counter by saturating increment if PCSrcE=1 and saturating decrement if PCSrcE=0, write target = PCTargetE when PCSrcE=1, and leave target unchanged when PCSrcE=0.
REQ-019 On BranchE that misses, SHALL allocate the entry only if PCSrcE=1, writing valid=1, tag, target = PCTargetE and counter = WEAK_T (10); a not-taken miss SHALL leave the entry unchanged.
REQ-020 On JumpE, SHALL allocate or overwrite the entry with counter = STRONG_T (11) and target = PCTargetE.
REQ-021 On a non-control instruction with PredTakenE=1 (stale entry), SHALL clear the valid bit of the entry at PCE.
REQ-022 SHALL perform at most one update per cycle, committed at the clock edge.
REQ-023 When fetch and update target the same index in the same cycle, SHALL return the pre-update contents to fetch (no write-through).
REQ-024 SHALL hold the counter at 11 under a further taken outcome and at 00 under a further not-taken outcome, with no wrap.
REQ-025 SHALL treat BranchE and JumpE both high as JumpE.

Reset
REQ-026 While rst_n=0 at a clock edge, SHALL clear all valid bits and set all counters to WEAK_NT (01); target and tag contents are don't-care.
REQ-027 SHALL discard an update coincident with reset.
REQ-028 After reset, SHALL output PredTakenF=0 and PredTargetF=PCF+4 for any PCF.
REQ-029 SHALL have no reset dependency for MispredictE and RedirectPCE, which follow their inputs.

Structure
REQ-030 SHALL take from shared package bp_pkg: enum bp_ctr_t {STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11} and the default ENTRIES constant.
REQ-031 SHALL implement the saturating next-state logic in one sub-module, bp_sat_ctr (in: bp_ctr_t cur, taken; out: bp_ctr_t next), instantiated once on the update path.
REQ-032 SHALL hold the table in flops (ENTRIES*(1+tag+XLEN+2) bits).

Verification
REQ-033 Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104.
REQ-034 Taken beq at PCE=0x100 with PCTargetE=0x80 and PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
REQ-035 Three taken then four not-taken resolutions at 0x100 -> counter 10,11,11,10,01,00,00; PredTakenF goes 1,1,1,1,0,0,0.
REQ-036 jal at 0x200 with target 0x400 -> counter 11; one not-taken cannot occur, and a re-resolve with target 0x500 and PredTargetE=0x400 -> MispredictE=1, RedirectPCE=0x500, entry target 0x500.
REQ-037 PCE=0x100 and PCF=0x140 (same index with ENTRIES=16) updated in the same cycle -> fetch sees the old entry, tag mismatch after the update -> PredTakenF=0.
REQ-038 Update asserted in the same cycle as rst_n=0 -> the table is cleared and the update is lost.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch predictor types: 2-bit confidence counter encoding and default BTB depth.
package bp_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bp_ctr_t;

   localparam int BP_ENTRIES = 16;

endpackage

// File: rtl/bp_sat_ctr.sv
// Two-bit saturating confidence counter: step toward taken or not-taken, never wrapping.
module bp_sat_ctr
   import bp_pkg::*;
(
   input  bp_ctr_t cur,
   input  logic    taken,
   output bp_ctr_t next
);

   always_comb begin
      next = cur;
      case (cur)
         STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  next = taken ? STRONG_T : WEAK_T;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch lookup plus execute-stage
// resolution that flags mispredicts and trains the table one entry per cycle.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PCF,
   output logic            PredTakenF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            PCSrcE,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PredTargetE,
   output logic            MispredictE,
   output logic [XLEN-1:0] RedirectPCE
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = XLEN - IDXW - 2;

   logic            valid_q  [ENTRIES];
   logic [TAGW-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0] target_q [ENTRIES];
   bp_ctr_t         ctr_q    [ENTRIES];

   logic [IDXW-1:0] idx_f;
   logic [TAGW-1:0] tag_f;
   logic            hit_f;
   bp_ctr_t         ctr_f;

   assign idx_f       = PCF[IDXW+1:2];
   assign tag_f       = PCF[XLEN-1:IDXW+2];
   assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign ctr_f       = ctr_q[idx_f];
   assign PredTakenF  = hit_f & ctr_f[1];
   assign PredTargetF = hit_f ? target_q[idx_f] : PCF + XLEN'(4);

   // Resolution is purely combinational and independent of reset.
   logic ctrl_e;
   assign ctrl_e      = BranchE | JumpE;
   assign MispredictE = (ctrl_e & ((PCSrcE != PredTakenE) |
                                   (PCSrcE & PredTakenE & (PredTargetE != PCTargetE))))
                      | (~BranchE & ~JumpE & PredTakenE);
   assign RedirectPCE = (ctrl_e & PCSrcE) ? PCTargetE : PCPlus4E;

   logic [IDXW-1:0] idx_e;
   logic [TAGW-1:0] tag_e;
   logic            hit_e;
   bp_ctr_t         ctr_next;

   assign idx_e = PCE[IDXW+1:2];
   assign tag_e = PCE[XLEN-1:IDXW+2];
   assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

   bp_sat_ctr u_sat_ctr (
      .cur   (ctr_q[idx_e]),
      .taken (PCSrcE),
      .next  (ctr_next)
   );

   logic            wr_en_d;
   logic            valid_d;
   logic [TAGW-1:0] tag_d;
   logic [XLEN-1:0] target_d;
   bp_ctr_t         ctr_d;

   // Jump wins over branch when both are set; a stale hit on a non-control op drops the entry.
   always_comb begin
      wr_en_d  = 1'b0;
      valid_d  = valid_q[idx_e];
      tag_d    = tag_e;
      target_d = target_q[idx_e];
      ctr_d    = ctr_q[idx_e];
      if (JumpE) begin
         wr_en_d  = 1'b1;
         valid_d  = 1'b1;
         target_d = PCTargetE;
         ctr_d    = STRONG_T;
      end else if (BranchE) begin
         if (hit_e) begin
            wr_en_d = 1'b1;
            ctr_d   = ctr_next;
            if (PCSrcE) target_d = PCTargetE;
         end else if (PCSrcE) begin
            wr_en_d  = 1'b1;
            valid_d  = 1'b1;
            target_d = PCTargetE;
            ctr_d    = WEAK_T;
         end
      end else if (PredTakenE) begin
         wr_en_d = 1'b1;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= WEAK_NT;
         end
      end else if (wr_en_d) begin
         valid_q[idx_e]  <= valid_d;
         tag_q[idx_e]    <= tag_d;
         target_q[idx_e] <= target_d;
         ctr_q[idx_e]    <= ctr_d;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: resolution vector table, directed training
// sequences, and randomized traffic against an array-based BTB model.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic [31:0] PCE, PCPlus4E, PCTargetE, PredTargetE;
   logic        BranchE, JumpE, PCSrcE, PredTakenE;
   logic        MispredictE;
   logic [31:0] RedirectPCE;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PCF         (PCF),
      .PredTakenF  (PredTakenF),
      .PredTargetF (PredTargetF),
      .PCE         (PCE),
      .PCPlus4E    (PCPlus4E),
      .PCTargetE   (PCTargetE),
      .BranchE     (BranchE),
      .JumpE       (JumpE),
      .PCSrcE      (PCSrcE),
      .PredTakenE  (PredTakenE),
      .PredTargetE (PredTargetE),
      .MispredictE (MispredictE),
      .RedirectPCE (RedirectPCE)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   typedef struct {
      logic        b;
      logic        j;
      logic        s;
      logic        pt;
      logic [31:0] ptg;
      logic        expMis;
      logic [31:0] expRed;
   } vec_t;

   vec_t vecs [11];

   // Reference table: one slot per BTB index, counter kept as an integer 0..3.
   bit          mValid  [16];
   logic [31:0] mTag    [16];
   logic [31:0] mTarget [16];
   int          mCtr    [16];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] pce, input logic [31:0] pcp4,
                                input logic [31:0] pct, input logic b, input logic j,
                                input logic s, input logic pt, input logic [31:0] ptg);
      PCE = pce; PCPlus4E = pcp4; PCTargetE = pct;
      BranchE = b; JumpE = j; PCSrcE = s; PredTakenE = pt; PredTargetE = ptg;
   endtask

   task automatic idle();
      applyStimulus(32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      idle();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) begin
         mValid[i] = 0;
         mCtr[i]   = 1;
      end
   endtask

   task automatic modelUpdate();
      int idx;
      logic [31:0] tg;
      bit hit;
      idx = int'((PCE >> 2) % 16);
      tg  = PCE >> 6;
      hit = mValid[idx] && (mTag[idx] == tg);
      if (!rst_n) begin
         modelReset();
      end else if (JumpE) begin
         mValid[idx] = 1; mTag[idx] = tg; mTarget[idx] = PCTargetE; mCtr[idx] = 3;
      end else if (BranchE) begin
         if (hit) begin
            if (PCSrcE) begin
               mCtr[idx]    = (mCtr[idx] == 3) ? 3 : mCtr[idx] + 1;
               mTarget[idx] = PCTargetE;
            end else begin
               mCtr[idx] = (mCtr[idx] == 0) ? 0 : mCtr[idx] - 1;
            end
         end else if (PCSrcE) begin
            mValid[idx] = 1; mTag[idx] = tg; mTarget[idx] = PCTargetE; mCtr[idx] = 2;
         end
      end else if (PredTakenE) begin
         mValid[idx] = 0;
      end
   endtask

   function automatic logic [31:0] randPc();
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      logic outcome [7];
      logic expTk   [7];
      int   fidx;
      bit   fhit, actTaken;
      logic expTakenF, expMis;
      logic [31:0] expTgtF, expRed;
      logic [1:0] cls;

      rst_n = 1'b0;
      PCF   = 32'h0;
      idle();
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2000};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h2000};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h2000};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 32'h1004};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 1'b0, 32'h1004};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2000};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h2000};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 32'h1004};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h1004};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h1004};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h2000};

      step();
      step();
      // Resolution outputs must follow inputs even while reset is held.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(32'h1000, 32'h1004, 32'h2000, vecs[i].b, vecs[i].j, vecs[i].s,
                       vecs[i].pt, vecs[i].ptg);
         #1;
         checkOutput($sformatf("vec%0d_mispredict", i), 32'(MispredictE), 32'(vecs[i].expMis));
         checkOutput($sformatf("vec%0d_redirect", i), RedirectPCE, vecs[i].expRed);
      end
      idle();
      step();
      rst_n = 1'b1;

      // Reset state: every fetch misses.
      for (int i = 0; i < 4; i++) begin
         PCF = 32'h100 + 32'(i * 32'h44);
         #1;
         checkOutput("reset_taken", 32'(PredTakenF), 32'h0);
         checkOutput("reset_target", PredTargetF, PCF + 32'h4);
      end

      // First taken branch: mispredict, then the entry predicts taken.
      applyStimulus(32'h100, 32'h104, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
      PCF = 32'h100;
      #1;
      checkOutput("beq_mispredict", 32'(MispredictE), 32'h1);
      checkOutput("beq_redirect", RedirectPCE, 32'h80);
      checkOutput("beq_pre_taken", 32'(PredTakenF), 32'h0);
      step();
      idle();
      #1;
      checkOutput("beq_post_taken", 32'(PredTakenF), 32'h1);
      checkOutput("beq_post_target", PredTargetF, 32'h80);

      // Counter saturation: T,T,T,N,N,N,N from a fresh table.
      doReset();
      outcome = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      expTk   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 7; k++) begin
         applyStimulus(32'h100, 32'h104, 32'h80, 1'b1, 1'b0, outcome[k], 1'b0, 32'h104);
         step();
         idle();
         PCF = 32'h100;
         #1;
         checkOutput($sformatf("sat_step%0d_taken", k), 32'(PredTakenF), 32'(expTk[k]));
      end

      // Jump allocates strong-taken; one not-taken branch keeps it taken.
      applyStimulus(32'h200, 32'h204, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      idle();
      PCF = 32'h200;
      #1;
      checkOutput("jal_taken", 32'(PredTakenF), 32'h1);
      checkOutput("jal_target", PredTargetF, 32'h400);
      applyStimulus(32'h200, 32'h204, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
      #1;
      checkOutput("jal_nt_mispredict", 32'(MispredictE), 32'h1);
      checkOutput("jal_nt_redirect", RedirectPCE, 32'h204);
      step();
      idle();
      #1;
      checkOutput("jal_nt_still_taken", 32'(PredTakenF), 32'h1);
      applyStimulus(32'h200, 32'h204, 32'h500, 1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
      #1;
      checkOutput("jal_retarget_mispredict", 32'(MispredictE), 32'h1);
      checkOutput("jal_retarget_redirect", RedirectPCE, 32'h500);
      step();
      idle();
      #1;
      checkOutput("jal_retarget_target", PredTargetF, 32'h500);
      checkOutput("jal_retarget_taken", 32'(PredTakenF), 32'h1);

      // Stale entry hit by a non-control instruction is invalidated.
      applyStimulus(32'h200, 32'h204, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500);
      #1;
      checkOutput("stale_mispredict", 32'(MispredictE), 32'h1);
      checkOutput("stale_redirect", RedirectPCE, 32'h204);
      step();
      idle();
      #1;
      checkOutput("stale_cleared_taken", 32'(PredTakenF), 32'h0);
      checkOutput("stale_cleared_target", PredTargetF, 32'h204);

      // Same-index fetch and update: fetch sees pre-update contents.
      doReset();
      applyStimulus(32'h140, 32'h144, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h144);
      step();
      applyStimulus(32'h100, 32'h104, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
      PCF = 32'h140;
      #1;
      checkOutput("alias_pre_taken", 32'(PredTakenF), 32'h1);
      checkOutput("alias_pre_target", PredTargetF, 32'h300);
      step();
      idle();
      #1;
      checkOutput("alias_post_taken", 32'(PredTakenF), 32'h0);
      checkOutput("alias_post_target", PredTargetF, 32'h144);
      PCF = 32'h100;
      #1;
      checkOutput("alias_new_taken", 32'(PredTakenF), 32'h1);
      checkOutput("alias_new_target", PredTargetF, 32'h80);

      // Update coincident with reset is dropped and the table is cleared.
      rst_n = 1'b0;
      applyStimulus(32'h200, 32'h204, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      idle();
      rst_n = 1'b1;
      PCF = 32'h200;
      #1;
      checkOutput("rst_upd_taken", 32'(PredTakenF), 32'h0);
      checkOutput("rst_upd_target", PredTargetF, 32'h204);
      PCF = 32'h100;
      #1;
      checkOutput("rst_clear_taken", 32'(PredTakenF), 32'h0);

      // Randomized traffic against the reference table.
      doReset();
      modelReset();
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(0, 40) != 0);
         cls   = 2'($urandom_range(0, 3));
         PCE   = randPc();
         applyStimulus(PCE, PCE + 32'h4, 32'($urandom) & ~32'h3, cls[0], cls[1],
                       1'($urandom), 1'($urandom),
                       ($urandom_range(0, 1) != 0) ? (32'($urandom) & ~32'h3) : 32'h0);
         if ($urandom_range(0, 2) == 0) PredTargetE = PCTargetE;
         PCF = randPc();
         #1;
         fidx = int'((PCF >> 2) % 16);
         fhit = mValid[fidx] && (mTag[fidx] == (PCF >> 6));
         expTakenF = fhit && (mCtr[fidx] >= 2);
         expTgtF   = fhit ? mTarget[fidx] : PCF + 32'h4;
         actTaken  = (BranchE || JumpE) && PCSrcE;
         expMis    = (actTaken != PredTakenE) || (actTaken && (PredTargetE != PCTargetE));
         expRed    = actTaken ? PCTargetE : PCPlus4E;
         checkOutput("rand_taken", 32'(PredTakenF), 32'(expTakenF));
         checkOutput("rand_target", PredTargetF, expTgtF);
         checkOutput("rand_mispredict", 32'(MispredictE), 32'(expMis));
         checkOutput("rand_redirect", RedirectPCE, expRed);
         modelUpdate();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
